// File: rtl/ram_bridge_if.sv
//------------------------------------------------------------------------------
// Module   : ram_bridge_if
// Purpose  : CPU-bus and SDRAM-controller signal bundle for ram_bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_bridge_if #(
  parameter int BUS_AW      = 20,
  parameter int MEM_AW      = 25,
  parameter int EMS_WINDOWS = 4,
  parameter int EMS_PAGE_W  = 7
) ();
  logic                              enable_sdram;
  logic [BUS_AW-1:0]                 address;
  logic [7:0]                        internal_data_bus;
  logic [7:0]                        data_bus_out;
  logic                              memory_read_n;
  logic                              memory_write_n;
  logic                              memory_access_ready;
  logic                              ram_address_select_n;
  logic [EMS_WINDOWS*EMS_PAGE_W-1:0] ems_map;
  logic [EMS_WINDOWS-1:0]            ems_hit;
  logic [MEM_AW-1:0]                 access_address;
  logic [15:0]                       access_data_in;
  logic                              write_request;
  logic                              read_request;
  logic                              write_flag;
  logic                              read_flag;
  logic [15:0]                       access_data_out;
  logic                              idle;
  logic                              post_full;

  modport slave (
    input  enable_sdram, address, internal_data_bus, memory_read_n, memory_write_n,
           ems_map, ems_hit, write_flag, read_flag, access_data_out, idle,
    output data_bus_out, memory_access_ready, ram_address_select_n, access_address,
           access_data_in, write_request, read_request, post_full
  );

  modport master (
    output enable_sdram, address, internal_data_bus, memory_read_n, memory_write_n,
           ems_map, ems_hit, write_flag, read_flag, access_data_out, idle,
    input  data_bus_out, memory_access_ready, ram_address_select_n, access_address,
           access_data_in, write_request, read_request, post_full
  );
endinterface

`default_nettype wire

// File: rtl/ram_bridge.sv
//------------------------------------------------------------------------------
// Module   : ram_bridge
// Purpose  : CPU-bus RAM front end with EMS windows and a posted-write FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_bridge #(
  parameter int BUS_AW      = 20,
  parameter int MEM_AW      = 25,
  parameter int EMS_WINDOWS = 4,
  parameter int EMS_PAGE_W  = 7,
  parameter int EMS_OFS_W   = 14,
  parameter int POST_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  ram_bridge_if.slave bif
);
  localparam int PTR_W = $clog2(POST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(POST_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t r_state, w_next;

  logic              w_sel, w_found, w_wr_start, w_rd_start;
  logic              w_full, w_pop, w_push, w_can_push;
  logic [MEM_AW-1:0] w_xlat, w_push_addr;
  logic [7:0]        w_push_data;
  logic              w_wreq, w_rreq;
  logic [MEM_AW-1:0] w_acc_addr;
  logic [15:0]       w_acc_data;
  logic              w_unused_hi;

  logic              r_rd_n_q, r_wr_n_q, r_wr_pend, r_rd_busy;
  logic [PTR_W-1:0]  r_wp, r_rp;
  logic [CNT_W-1:0]  r_cnt;
  logic [MEM_AW-1:0] r_cur_addr, r_rd_addr, r_pend_addr;
  logic [7:0]        r_cur_data, r_pend_data, r_rd_data, r_dout;
  logic [MEM_AW-1:0] r_fifo_addr [POST_DEPTH];
  logic [7:0]        r_fifo_data [POST_DEPTH];

  // Lowest-numbered hitting window owns the translation.
  always_comb begin
    w_found = 1'b0;
    w_xlat  = MEM_AW'(bif.address);
    for (int i = 0; i < EMS_WINDOWS; i++) begin
      if (!w_found && bif.ems_hit[i]) begin
        w_found = 1'b1;
        w_xlat  = MEM_AW'({1'b1, bif.ems_map[i*EMS_PAGE_W +: EMS_PAGE_W],
                           bif.address[EMS_OFS_W-1:0]});
      end
    end
  end

  assign w_sel = bif.enable_sdram
              && (bif.address[BUS_AW-1 -: 4] != 4'hB)
              && (bif.address[BUS_AW-1 -: 4] != 4'hF);

  assign w_wr_start = w_sel && !bif.memory_write_n && r_wr_n_q;
  assign w_rd_start = w_sel && !bif.memory_read_n && r_rd_n_q && !w_wr_start;

  assign w_full      = (r_cnt == C_FULL);
  assign w_pop       = (r_state == S_IDLE) && (r_cnt != '0);
  assign w_can_push  = !w_full || w_pop;
  assign w_push      = (w_wr_start || r_wr_pend) && w_can_push;
  assign w_push_addr = r_wr_pend ? r_pend_addr : w_xlat;
  assign w_push_data = r_wr_pend ? r_pend_data : bif.internal_data_bus;

  always_comb begin
    w_next     = r_state;
    w_wreq     = 1'b0;
    w_rreq     = 1'b0;
    w_acc_addr = '0;
    w_acc_data = '0;
    case (r_state)
      S_IDLE: begin
        if (r_cnt != '0)    w_next = S_WR_REQ;
        else if (r_rd_busy) w_next = S_RD_REQ;
      end
      S_WR_REQ: begin
        w_wreq     = 1'b1;
        w_acc_addr = r_cur_addr;
        w_acc_data = {8'h00, r_cur_data};
        if (bif.write_flag) w_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        w_acc_addr = r_cur_addr;
        w_acc_data = {8'h00, r_cur_data};
        if (!bif.write_flag) w_next = S_IDLE;
      end
      S_RD_REQ: begin
        w_rreq     = 1'b1;
        w_acc_addr = r_rd_addr;
        if (bif.memory_read_n)  w_next = S_ABORT;
        else if (bif.read_flag) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_acc_addr = r_rd_addr;
        if (bif.memory_read_n)   w_next = S_ABORT;
        else if (!bif.read_flag) w_next = S_DONE;
      end
      S_DONE:  if (bif.memory_read_n) w_next = S_IDLE;
      S_ABORT: if (bif.idle)          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd_n_q    <= 1'b1;
      r_wr_n_q    <= 1'b1;
      r_wr_pend   <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_cur_addr  <= '0;
      r_cur_data  <= '0;
      r_rd_addr   <= '0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_rd_data   <= '0;
      r_dout      <= '0;
    end else begin
      r_state  <= w_next;
      r_rd_n_q <= bif.memory_read_n;
      r_wr_n_q <= bif.memory_write_n;

      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop) begin
        r_rp       <= r_rp + PTR_W'(1);
        r_cur_addr <= r_fifo_addr[r_rp];
        r_cur_data <= r_fifo_data[r_rp];
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);

      // A write that finds the FIFO full is parked here and the bus is stalled.
      if (w_wr_start && !w_can_push) begin
        r_wr_pend   <= 1'b1;
        r_pend_addr <= w_xlat;
        r_pend_data <= bif.internal_data_bus;
      end else if (w_push) begin
        r_wr_pend <= 1'b0;
      end

      if (w_rd_start) begin
        r_rd_busy <= 1'b1;
        r_rd_addr <= w_xlat;
      end else if (bif.memory_read_n || (r_state == S_RD_WAIT && w_next == S_DONE)) begin
        r_rd_busy <= 1'b0;
      end

      if (r_state == S_RD_REQ && w_next == S_RD_WAIT) r_rd_data <= bif.access_data_out[7:0];
      if (r_state == S_RD_WAIT && w_next == S_DONE)   r_dout    <= r_rd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wp] <= w_push_addr;
      r_fifo_data[r_wp] <= w_push_data;
    end
  end

  assign w_unused_hi = ^bif.access_data_out[15:8];

  assign bif.ram_address_select_n = ~w_sel;
  assign bif.memory_access_ready  = ~w_sel | ~(r_wr_pend | r_rd_busy);
  assign bif.data_bus_out         = r_dout;
  assign bif.post_full            = w_full;
  assign bif.write_request        = w_wreq;
  assign bif.read_request         = w_rreq;
  assign bif.access_address       = w_acc_addr;
  assign bif.access_data_in       = w_acc_data;
endmodule

`default_nettype wire
